// File: rtl/frogger_pkg.sv
// Shared Frogger definitions: state encodings, datapath widths and default game tuning.
// Used by the game controller, its handshake interface and the score display.
package frogger_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'b000,
      ST_RUNNING   = 3'b001,
      ST_HIT       = 3'b010,
      ST_GOAL      = 3'b011,
      ST_GAME_OVER = 3'b100,
      ST_WIN       = 3'b101
   } state_t;

   localparam int STATE_W = 3;
   localparam int FRAME_W = 6;
   localparam int SCORE_W = 7;
   localparam int LIVES_W = 3;

   localparam int DEF_SCORE_LIMIT = 99;
   localparam int DEF_START_LIVES = 3;
   localparam int DEF_HOLD_FRAMES = 30;

   // States from which a start press launches a fresh game.
   function automatic logic accepts_start(input state_t s);
      return (s == ST_IDLE) || (s == ST_GAME_OVER) || (s == ST_WIN);
   endfunction

endpackage

// File: rtl/game_state_ctrl_if.sv
// Player/video-side inputs and game status outputs of the Frogger state controller.
// The master drives the game inputs; the slave (controller) drives the status.
interface game_state_ctrl_if;
   import frogger_pkg::*;

   logic               i_Game_Start;
   logic               i_Frame_Tick;
   logic               i_Collision;
   logic               i_Frog_At_Goal;
   logic [STATE_W-1:0] o_State;
   logic               o_Game_Active;
   logic [SCORE_W-1:0] o_Score;
   logic [LIVES_W-1:0] o_Lives;
   logic               o_Frog_Reset;

   modport master (
      output i_Game_Start, i_Frame_Tick, i_Collision, i_Frog_At_Goal,
      input  o_State, o_Game_Active, o_Score, o_Lives, o_Frog_Reset
   );

   modport slave (
      input  i_Game_Start, i_Frame_Tick, i_Collision, i_Frog_At_Goal,
      output o_State, o_Game_Active, o_Score, o_Lives, o_Frog_Reset
   );

endinterface

// File: rtl/game_state_ctrl_edge_detect.sv
// Rising-edge detector against a registered copy of the level; one pulse per press.
// Reset loads the live level so a button held through reset produces no edge.
module edge_detect (
   input  logic clk,
   input  logic rst,
   input  logic level,
   output logic pulse
);

   logic level_q;

   always_ff @(posedge clk) begin
      if (rst) level_q <= level;
      else     level_q <= level;
   end

   assign pulse = level & ~level_q;

endmodule

// File: rtl/game_state_ctrl.sv
// Frogger game flow controller: start/run/hit/goal/end states with score, lives
// and a frame-counted hold after each hit or goal. All outputs are registered.
module game_state_ctrl
   import frogger_pkg::*;
#(
   parameter int c_SCORE_LIMIT = DEF_SCORE_LIMIT,
   parameter int c_START_LIVES = DEF_START_LIVES,
   parameter int c_HOLD_FRAMES = DEF_HOLD_FRAMES
) (
   input logic              i_Clk,
   input logic              i_Rst,
   game_state_ctrl_if.slave bus
);

   localparam logic [SCORE_W-1:0] SCORE_MAX  = SCORE_W'(c_SCORE_LIMIT);
   localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(c_START_LIVES);
   localparam logic [FRAME_W-1:0] HOLD_LAST  = FRAME_W'(c_HOLD_FRAMES - 1);

   state_t             state, state_nxt;
   logic [SCORE_W-1:0] score, score_nxt;
   logic [LIVES_W-1:0] lives, lives_nxt;
   logic [FRAME_W-1:0] frame_cnt, frame_cnt_nxt;
   logic               frog_reset, frog_reset_nxt;
   logic               game_active, game_active_nxt;
   logic               start_evt;
   logic               start_load;
   logic               hold_done;

   function automatic logic [SCORE_W-1:0] sat_inc_score(input logic [SCORE_W-1:0] s);
      return (s >= SCORE_MAX) ? SCORE_MAX : s + 1'b1;
   endfunction

   function automatic logic [LIVES_W-1:0] sat_dec_lives(input logic [LIVES_W-1:0] l);
      return (l == '0) ? '0 : l - 1'b1;
   endfunction

   edge_detect u_start_edge (
      .clk   (i_Clk),
      .rst   (i_Rst),
      .level (bus.i_Game_Start),
      .pulse (start_evt)
   );

   assign start_load = start_evt && accepts_start(state);
   // The tick that completes the hold is the exit cycle, not the one after it.
   assign hold_done  = bus.i_Frame_Tick && (frame_cnt == HOLD_LAST);

   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         state       <= ST_IDLE;
         score       <= '0;
         lives       <= LIVES_INIT;
         frame_cnt   <= '0;
         frog_reset  <= 1'b0;
         game_active <= 1'b0;
      end else begin
         state       <= state_nxt;
         score       <= score_nxt;
         lives       <= lives_nxt;
         frame_cnt   <= frame_cnt_nxt;
         frog_reset  <= frog_reset_nxt;
         game_active <= game_active_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE, ST_GAME_OVER, ST_WIN: begin
            if (start_load) state_nxt = ST_RUNNING;
         end
         ST_RUNNING: begin
            if (bus.i_Collision)         state_nxt = ST_HIT;
            else if (bus.i_Frog_At_Goal) state_nxt = ST_GOAL;
         end
         ST_HIT: begin
            if (hold_done) state_nxt = (lives == '0) ? ST_GAME_OVER : ST_RUNNING;
         end
         ST_GOAL: begin
            if (hold_done) state_nxt = (score == SCORE_MAX) ? ST_WIN : ST_RUNNING;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      score_nxt     = score;
      lives_nxt     = lives;
      frame_cnt_nxt = frame_cnt;
      case (state)
         ST_IDLE, ST_GAME_OVER, ST_WIN: begin
            if (start_load) begin
               score_nxt     = '0;
               lives_nxt     = LIVES_INIT;
               frame_cnt_nxt = '0;
            end
         end
         ST_RUNNING: begin
            frame_cnt_nxt = '0;
            // Collision has priority; a simultaneous goal does not score.
            if (bus.i_Collision)         lives_nxt = sat_dec_lives(lives);
            else if (bus.i_Frog_At_Goal) score_nxt = sat_inc_score(score);
         end
         ST_HIT, ST_GOAL: begin
            if (hold_done)              frame_cnt_nxt = '0;
            else if (bus.i_Frame_Tick)  frame_cnt_nxt = frame_cnt + 1'b1;
         end
         default: frame_cnt_nxt = '0;
      endcase
      frog_reset_nxt  = (state_nxt == ST_RUNNING) && (state != ST_RUNNING);
      game_active_nxt = (state_nxt == ST_RUNNING);
   end

   assign bus.o_State       = state;
   assign bus.o_Game_Active = game_active;
   assign bus.o_Score       = score;
   assign bus.o_Lives       = lives;
   assign bus.o_Frog_Reset  = frog_reset;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Directed bench for game_state_ctrl: one instance with default tuning, one with
// a score limit of 3 and a 4-frame hold for the win path.
module tb_game_state_ctrl;

   logic clk = 1'b0;
   logic rst;
   int   n_chk  = 0;
   int   n_fail = 0;

   game_state_ctrl_if bus_a ();
   game_state_ctrl_if bus_b ();

   game_state_ctrl dut_a (
      .i_Clk (clk),
      .i_Rst (rst),
      .bus   (bus_a.slave)
   );

   game_state_ctrl #(
      .c_SCORE_LIMIT (3),
      .c_START_LIVES (3),
      .c_HOLD_FRAMES (4)
   ) dut_b (
      .i_Clk (clk),
      .i_Rst (rst),
      .bus   (bus_b.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic tick_a(input int n);
      for (int i = 0; i < n; i++) begin
         bus_a.i_Frame_Tick = 1'b1;
         step();
         bus_a.i_Frame_Tick = 1'b0;
         step();
      end
   endtask

   task automatic tick_b(input int n);
      for (int i = 0; i < n; i++) begin
         bus_b.i_Frame_Tick = 1'b1;
         step();
         bus_b.i_Frame_Tick = 1'b0;
         step();
      end
   endtask

   initial begin
      rst                  = 1'b1;
      bus_a.i_Game_Start   = 1'b1;
      bus_a.i_Frame_Tick   = 1'b0;
      bus_a.i_Collision    = 1'b0;
      bus_a.i_Frog_At_Goal = 1'b0;
      bus_b.i_Game_Start   = 1'b0;
      bus_b.i_Frame_Tick   = 1'b0;
      bus_b.i_Collision    = 1'b0;
      bus_b.i_Frog_At_Goal = 1'b0;

      // Reset with start button held
      step();
      chk("rst_state",  bus_a.o_State, 0);
      chk("rst_score",  bus_a.o_Score, 0);
      chk("rst_lives",  bus_a.o_Lives, 3);
      chk("rst_frog",   bus_a.o_Frog_Reset, 0);
      chk("rst_active", bus_a.o_Game_Active, 0);
      step();
      rst = 1'b0;
      step(); step(); step();
      chk("held_btn_idle", bus_a.o_State, 0);

      // Release then press: single start
      bus_a.i_Game_Start = 1'b0;
      step();
      bus_a.i_Game_Start = 1'b1;
      step();
      chk("start_state",  bus_a.o_State, 1);
      chk("start_score",  bus_a.o_Score, 0);
      chk("start_lives",  bus_a.o_Lives, 3);
      chk("start_frog",   bus_a.o_Frog_Reset, 1);
      chk("start_active", bus_a.o_Game_Active, 1);
      step();
      chk("start_frog_1cyc", bus_a.o_Frog_Reset, 0);
      chk("start_held_run",  bus_a.o_State, 1);

      // Start press while running is ignored
      bus_a.i_Game_Start = 1'b0;
      step();
      bus_a.i_Game_Start = 1'b1;
      step();
      chk("run_start_state", bus_a.o_State, 1);
      chk("run_start_lives", bus_a.o_Lives, 3);
      chk("run_start_frog",  bus_a.o_Frog_Reset, 0);
      bus_a.i_Game_Start = 1'b0;
      step();

      // First hit
      bus_a.i_Collision = 1'b1;
      step();
      bus_a.i_Collision = 1'b0;
      chk("hit1_state",  bus_a.o_State, 2);
      chk("hit1_lives",  bus_a.o_Lives, 2);
      chk("hit1_active", bus_a.o_Game_Active, 0);
      bus_a.i_Game_Start = 1'b1;
      step();
      chk("hit_start_state", bus_a.o_State, 2);
      chk("hit_start_lives", bus_a.o_Lives, 2);
      chk("hit_start_score", bus_a.o_Score, 0);
      bus_a.i_Game_Start = 1'b0;
      step();
      tick_a(29);
      chk("hit1_hold29", bus_a.o_State, 2);
      bus_a.i_Frame_Tick = 1'b1;
      step();
      bus_a.i_Frame_Tick = 1'b0;
      chk("hit1_exit_state", bus_a.o_State, 1);
      chk("hit1_exit_frog",  bus_a.o_Frog_Reset, 1);
      step();
      chk("hit1_frog_1cyc", bus_a.o_Frog_Reset, 0);

      // Second and third hits
      bus_a.i_Collision = 1'b1;
      step();
      bus_a.i_Collision = 1'b0;
      chk("hit2_lives", bus_a.o_Lives, 1);
      tick_a(30);
      chk("hit2_exit", bus_a.o_State, 1);
      bus_a.i_Collision = 1'b1;
      step();
      bus_a.i_Collision = 1'b0;
      chk("hit3_lives", bus_a.o_Lives, 0);
      tick_a(29);
      bus_a.i_Frame_Tick = 1'b1;
      step();
      bus_a.i_Frame_Tick = 1'b0;
      chk("gameover_state", bus_a.o_State, 4);
      chk("gameover_frog",  bus_a.o_Frog_Reset, 0);
      chk("gameover_lives", bus_a.o_Lives, 0);
      bus_a.i_Collision = 1'b1;
      step();
      bus_a.i_Collision = 1'b0;
      chk("gameover_coll_ign", bus_a.o_State, 4);
      chk("gameover_lives_hold", bus_a.o_Lives, 0);

      // Restart from GAME_OVER
      bus_a.i_Game_Start = 1'b1;
      step();
      bus_a.i_Game_Start = 1'b0;
      chk("restart_state", bus_a.o_State, 1);
      chk("restart_lives", bus_a.o_Lives, 3);
      chk("restart_frog",  bus_a.o_Frog_Reset, 1);
      step();

      // Goal, then collision+goal together
      bus_a.i_Frog_At_Goal = 1'b1;
      step();
      bus_a.i_Frog_At_Goal = 1'b0;
      chk("goal1_state", bus_a.o_State, 3);
      chk("goal1_score", bus_a.o_Score, 1);
      tick_a(30);
      chk("goal1_exit", bus_a.o_State, 1);
      bus_a.i_Collision    = 1'b1;
      bus_a.i_Frog_At_Goal = 1'b1;
      step();
      bus_a.i_Collision    = 1'b0;
      bus_a.i_Frog_At_Goal = 1'b0;
      chk("both_state", bus_a.o_State, 2);
      chk("both_score", bus_a.o_Score, 1);
      chk("both_lives", bus_a.o_Lives, 2);
      tick_a(30);
      chk("both_exit", bus_a.o_State, 1);

      // Reset in the middle of a goal hold
      bus_a.i_Frog_At_Goal = 1'b1;
      step();
      bus_a.i_Frog_At_Goal = 1'b0;
      chk("goal2_score", bus_a.o_Score, 2);
      tick_a(10);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("midrst_state",  bus_a.o_State, 0);
      chk("midrst_score",  bus_a.o_Score, 0);
      chk("midrst_lives",  bus_a.o_Lives, 3);
      chk("midrst_active", bus_a.o_Game_Active, 0);
      step();
      chk("midrst_stay_idle", bus_a.o_State, 0);

      // Small score limit: win path
      bus_b.i_Game_Start = 1'b1;
      step();
      bus_b.i_Game_Start = 1'b0;
      chk("b_start_state", bus_b.o_State, 1);
      chk("b_start_score", bus_b.o_Score, 0);
      step();
      for (int g = 1; g <= 3; g++) begin
         bus_b.i_Frog_At_Goal = 1'b1;
         step();
         bus_b.i_Frog_At_Goal = 1'b0;
         chk("b_goal_state", bus_b.o_State, 3);
         chk("b_goal_score", bus_b.o_Score, g);
         tick_b(3);
         bus_b.i_Frame_Tick = 1'b1;
         step();
         bus_b.i_Frame_Tick = 1'b0;
         chk("b_goal_exit_state", bus_b.o_State, (g < 3) ? 1 : 5);
         chk("b_goal_exit_frog",  bus_b.o_Frog_Reset, (g < 3) ? 1 : 0);
         step();
      end
      bus_b.i_Frog_At_Goal = 1'b1;
      step();
      bus_b.i_Frog_At_Goal = 1'b0;
      chk("b_win_goal_ign_state", bus_b.o_State, 5);
      chk("b_win_goal_ign_score", bus_b.o_Score, 3);
      bus_b.i_Collision = 1'b1;
      step();
      bus_b.i_Collision = 1'b0;
      chk("b_win_coll_ign_lives", bus_b.o_Lives, 3);
      bus_b.i_Game_Start = 1'b1;
      step();
      bus_b.i_Game_Start = 1'b0;
      chk("b_restart_state", bus_b.o_State, 1);
      chk("b_restart_score", bus_b.o_Score, 0);
      chk("b_restart_frog",  bus_b.o_Frog_Reset, 1);
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
